// File: rtl/digit_serial_alu_loop.sv
// digit_serial_alu_loop
//   Digit-serial ALU sequencer. Works on one DIGIT_W-bit digit per clock
//   across a word of up to NUM_DIGITS digits. Supported operations are
//   ADD, SUB, COMP (A-B-1), EQ, right shift, AND, OR and XOR. The block has
//   a start/ready/done handshake, a variable operand length, sign extension
//   of B, early termination and a synchronous flush.
//
//   Optional feature: define DIGIT_LOOP_ZERO_FLAG_EN to add the 'zero'
//   output. It is set when every result bit is zero, updated together with
//   done and held with result.
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   start, ready   request; accepted when start && ready (ready = IDLE)
//   flush          synchronous abort of a running operation (no done)
//   op             0 ADD, 1 SUB, 2 COMP, 3 EQ, 4 RSHFT, 5 AND, 6 OR, 7 XOR
//   len            index of the last significant digit
//   carry_in       initial carry, or the shift-in bit for RSHFT
//   b_sign_ext     digits of word2 above len read as all-ones
//   word1, word2   operands A and B
//   preinit        initial result image for digits that are not written
//   busy, done     state != IDLE; one-cycle completion pulse
//   result         result word, held until the next accepted start
//   carry_out      final carry or the last shifted-out bit
//   eq             EQ op: every compared digit matched
//   zero           (DIGIT_LOOP_ZERO_FLAG_EN only) result is all zeros
module digit_serial_alu_loop #(
  parameter  int DIGIT_W    = 4,
  parameter  int NUM_DIGITS = 8,
  localparam int WORD_W     = DIGIT_W * NUM_DIGITS,
  localparam int LEN_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              ready,
  input  logic              flush,
  input  logic [2:0]        op,
  input  logic [LEN_W-1:0]  len,
  input  logic              carry_in,
  input  logic              b_sign_ext,
  input  logic [WORD_W-1:0] word1,
  input  logic [WORD_W-1:0] word2,
  input  logic [WORD_W-1:0] preinit,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] result,
  output logic              carry_out,
  output logic              eq
`ifdef DIGIT_LOOP_ZERO_FLAG_EN
  ,
  output logic              zero
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_COMP  = 3'd2,
    OP_EQ    = 3'd3,
    OP_RSHFT = 3'd4,
    OP_AND   = 3'd5,
    OP_OR    = 3'd6,
    OP_XOR   = 3'd7
  } op_e;

  localparam logic [LEN_W-1:0] LAST_IDX   = LEN_W'(NUM_DIGITS - 1);
  // One bit wider so the clamp compare stays meaningful when NUM_DIGITS is a power of two
  localparam logic [LEN_W:0]   LAST_IDX_X = (LEN_W + 1)'(NUM_DIGITS - 1);

  state_e              state, state_next;
  op_e                 op_reg;
  logic [WORD_W-1:0]   a_reg, b_reg;
  logic [LEN_W-1:0]    len_reg, idx, idx_next, len_clamped;
  logic                sext_reg, carry, carry_next, eq_next, stop;
  logic                accept;
  logic [31:0]         bit_base;
  logic [DIGIT_W-1:0]  a_dig, b_raw, b_dig, xnor_dig, digit_val;
  logic [DIGIT_W:0]    sum;
  logic [WORD_W-1:0]   result_next;

  assign accept      = (state == S_IDLE) && start;
  assign len_clamped = ({1'b0, len} > LAST_IDX_X) ? LAST_IDX : len;
  assign carry_out   = carry;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next state and handshake outputs; flush only matters once an operation is running
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
        if (start) state_next = S_RUN;
      end
      S_RUN: begin
        if (flush)     state_next = S_IDLE;
        else if (stop) state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Per-digit datapath: one digit result, the next carry/eq/index, and the stop decision
  always_comb begin
    bit_base   = 32'(idx) * 32'(DIGIT_W);
    a_dig      = a_reg[bit_base +: DIGIT_W];
    b_raw      = (idx <= len_reg) ? b_reg[bit_base +: DIGIT_W] : {DIGIT_W{sext_reg}};
    b_dig      = (op_reg == OP_SUB || op_reg == OP_COMP) ? ~b_raw : b_raw;
    sum        = {1'b0, a_dig} + {1'b0, b_dig} + (DIGIT_W + 1)'(carry);
    xnor_dig   = ~(a_dig ^ b_dig);
    digit_val  = '0;
    carry_next = carry;
    eq_next    = eq;
    stop       = 1'b0;
    idx_next   = idx + LEN_W'(1);
    case (op_reg)
      OP_ADD, OP_SUB, OP_COMP: begin
        digit_val  = sum[DIGIT_W-1:0];
        carry_next = sum[DIGIT_W];
        // Keep going past len while a carry is still rippling, never past the top digit
        stop       = ((idx >= len_reg) && !sext_reg && !sum[DIGIT_W]) || (idx == LAST_IDX);
      end
      OP_EQ: begin
        digit_val = xnor_dig;
        eq_next   = eq & (&xnor_dig);
        stop      = !(&xnor_dig) || (idx >= len_reg);
      end
      OP_RSHFT: begin
        digit_val  = {carry, b_raw[DIGIT_W-1:1]};
        carry_next = b_raw[0];
        stop       = (idx == '0);
        idx_next   = idx - LEN_W'(1);
      end
      OP_AND: begin
        digit_val  = a_dig & b_dig;
        carry_next = 1'b0;
        stop       = (idx >= len_reg);
      end
      OP_OR: begin
        digit_val  = a_dig | b_dig;
        carry_next = 1'b0;
        stop       = (idx >= len_reg);
      end
      OP_XOR: begin
        digit_val  = a_dig ^ b_dig;
        carry_next = 1'b0;
        stop       = (idx >= len_reg);
      end
      default: stop = 1'b1;
    endcase
    result_next = result;
    result_next[bit_base +: DIGIT_W] = digit_val;
  end

  // Operand capture on accept, then one digit written per RUN cycle unless flushed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      op_reg   <= OP_ADD;
      len_reg  <= '0;
      sext_reg <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      eq       <= 1'b0;
      idx      <= '0;
    end else if (accept) begin
      a_reg    <= word1;
      b_reg    <= word2;
      op_reg   <= op_e'(op);
      len_reg  <= len_clamped;
      sext_reg <= b_sign_ext;
      result   <= preinit;
      carry    <= carry_in;
      eq       <= 1'b1;
      idx      <= (op_e'(op) == OP_RSHFT) ? len_clamped : '0;
    end else if (state == S_RUN && !flush) begin
      result   <= result_next;
      carry    <= carry_next;
      eq       <= eq_next;
      idx      <= idx_next;
    end
  end

`ifdef DIGIT_LOOP_ZERO_FLAG_EN
  // Captured from the final digit write so it becomes valid in the same cycle as done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   zero <= 1'b0;
    else if (state == S_RUN && !flush && stop)    zero <= (result_next == '0);
  end
`endif

endmodule

// File: tb/tb_digit_serial_alu_loop.sv
// tb_digit_serial_alu_loop
//   Directed, table-driven bench for digit_serial_alu_loop with
//   DIGIT_W=4 and NUM_DIGITS=8. Each table row holds the inputs and the
//   hand-computed result, carry_out, eq and start-to-done latency. Added
//   sequences cover flush, start while busy, flush together with start,
//   and reset in the middle of an operation.
module tb_digit_serial_alu_loop;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        ready;
  logic        flush;
  logic [2:0]  op;
  logic [2:0]  len;
  logic        carry_in;
  logic        b_sign_ext;
  logic [31:0] word1;
  logic [31:0] word2;
  logic [31:0] preinit;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        carry_out;
  logic        eq;

  int pass_count  = 0;
  int check_count = 0;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [2:0]  len;
    logic        cin;
    logic        sext;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] pre;
    logic [31:0] exp_res;
    logic        exp_c;
    logic        exp_eq;
    logic [31:0] exp_lat;
  } vec_t;

  vec_t vecs[15];

  digit_serial_alu_loop #(.DIGIT_W(4), .NUM_DIGITS(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .ready      (ready),
    .flush      (flush),
    .op         (op),
    .len        (len),
    .carry_in   (carry_in),
    .b_sign_ext (b_sign_ext),
    .word1      (word1),
    .word2      (word2),
    .preinit    (preinit),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .carry_out  (carry_out),
    .eq         (eq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  // Starts one operation at a falling edge and waits, with a bound, for done.
  // lat is the number of cycles from the start cycle to the done cycle.
  task automatic applyStimulus(input vec_t v, input logic flush_with_start, output logic [31:0] lat);
    @(negedge clk);
    op         = v.op;
    len        = v.len;
    carry_in   = v.cin;
    b_sign_ext = v.sext;
    word1      = v.w1;
    word2      = v.w2;
    preinit    = v.pre;
    start      = 1'b1;
    flush      = flush_with_start;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    lat   = 1;
    while (!done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    logic [31:0] lat;

    //            name          op    len   cin   sext  word1         word2         preinit       result        c     eq    lat
    vecs[0]  = '{"add_len0",    3'd0, 3'd0, 1'b0, 1'b0, 32'h00FF0004, 32'h00000004, 32'h00FF0004, 32'h00FF0008, 1'b0, 1'b1, 32'd2};
    vecs[1]  = '{"add_ripple",  3'd0, 3'd7, 1'b0, 1'b0, 32'h0EFFFFFF, 32'h00000001, 32'h00000000, 32'h0F000000, 1'b0, 1'b1, 32'd9};
    vecs[2]  = '{"sub",         3'd1, 3'd7, 1'b1, 1'b0, 32'h00001000, 32'h00000500, 32'h00000000, 32'h00000B00, 1'b1, 1'b1, 32'd9};
    vecs[3]  = '{"add_sext",    3'd0, 3'd2, 1'b0, 1'b1, 32'h00000000, 32'h00000800, 32'h00000000, 32'hFFFFF800, 1'b0, 1'b1, 32'd9};
    vecs[4]  = '{"eq_match",    3'd3, 3'd7, 1'b0, 1'b0, 32'h12341234, 32'h12341234, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b1, 32'd9};
    vecs[5]  = '{"eq_miss",     3'd3, 3'd7, 1'b0, 1'b0, 32'h12341134, 32'h12341234, 32'h00000000, 32'h00000CFF, 1'b0, 1'b0, 32'd4};
    vecs[6]  = '{"rshft",       3'd4, 3'd7, 1'b0, 1'b0, 32'h00000000, 32'h06000000, 32'h00000000, 32'h03000000, 1'b0, 1'b1, 32'd9};
    vecs[7]  = '{"rshft_cin",   3'd4, 3'd1, 1'b1, 1'b0, 32'h00000000, 32'h00000035, 32'hAAAAAAAA, 32'hAAAAAA9A, 1'b1, 1'b1, 32'd3};
    vecs[8]  = '{"and",         3'd5, 3'd3, 1'b1, 1'b0, 32'hFFFF00FF, 32'h0F0F0F0F, 32'h12345678, 32'h1234000F, 1'b0, 1'b1, 32'd5};
    vecs[9]  = '{"or",          3'd6, 3'd1, 1'b0, 1'b0, 32'h000000A0, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFA5, 1'b0, 1'b1, 32'd3};
    vecs[10] = '{"xor",         3'd7, 3'd7, 1'b0, 1'b0, 32'h12345678, 32'hFFFFFFFF, 32'h00000000, 32'hEDCBA987, 1'b0, 1'b1, 32'd9};
    vecs[11] = '{"add_carry",   3'd0, 3'd0, 1'b0, 1'b0, 32'h000000FF, 32'h00000001, 32'h00000000, 32'h00000100, 1'b0, 1'b1, 32'd4};
    vecs[12] = '{"add_top",     3'd0, 3'd0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h00000000, 1'b1, 1'b1, 32'd9};
    vecs[13] = '{"comp",        3'd2, 3'd0, 1'b0, 1'b0, 32'h00000005, 32'h00000003, 32'h00000000, 32'h00000001, 1'b1, 1'b1, 32'd9};
    vecs[14] = '{"sub_borrow",  3'd1, 3'd0, 1'b1, 1'b0, 32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000E, 1'b0, 1'b1, 32'd2};

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; len = 3'd0;
    carry_in = 1'b0; b_sign_ext = 1'b0; word1 = '0; word2 = '0; preinit = '0;

    #3;
    checkOutput("rst_ready",  {31'd0, ready},     32'd1);
    checkOutput("rst_busy",   {31'd0, busy},      32'd0);
    checkOutput("rst_done",   {31'd0, done},      32'd0);
    checkOutput("rst_result", result,             32'd0);
    checkOutput("rst_carry",  {31'd0, carry_out}, 32'd0);
    checkOutput("rst_eq",     {31'd0, eq},        32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i], 1'b0, lat);
      checkOutput({vecs[i].name, "_done"},   {31'd0, done},      32'd1);
      checkOutput({vecs[i].name, "_lat"},    lat,                vecs[i].exp_lat);
      checkOutput({vecs[i].name, "_result"}, result,             vecs[i].exp_res);
      checkOutput({vecs[i].name, "_carry"},  {31'd0, carry_out}, {31'd0, vecs[i].exp_c});
      checkOutput({vecs[i].name, "_eq"},     {31'd0, eq},        {31'd0, vecs[i].exp_eq});
      @(negedge clk);
      checkOutput({vecs[i].name, "_pulse"},  {30'd0, done, ready}, 32'd1);
    end

    // Flush in RUN: two digits written, then back to IDLE without done
    @(negedge clk);
    op = 3'd0; len = 3'd7; carry_in = 1'b0; b_sign_ext = 1'b0;
    word1 = 32'h0; word2 = 32'h11111111; preinit = 32'hFFFFFFFF; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    checkOutput("flush_result", result, 32'hFFFFFF11);
    checkOutput("flush_idle",   {29'd0, ready, busy, done}, 32'b100);
    @(negedge clk);
    checkOutput("flush_nodone", {31'd0, done}, 32'd0);

    // start while busy must be ignored
    @(negedge clk);
    op = 3'd0; len = 3'd7; carry_in = 1'b0; b_sign_ext = 1'b0;
    word1 = 32'h0EFFFFFF; word2 = 32'h00000001; preinit = 32'h0; start = 1'b1;
    @(negedge clk);
    lat = 1;
    op = 3'd7; word1 = 32'hDEADBEEF; word2 = 32'h12345678; preinit = 32'h55555555;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    while (!done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("busy_start_lat",    lat,    32'd9);
    checkOutput("busy_start_result", result, 32'h0F000000);
    @(negedge clk);
    @(negedge clk);
    checkOutput("busy_start_idle", {30'd0, ready, busy}, 32'b10);

    // flush together with start in IDLE: the start is taken
    applyStimulus(vecs[0], 1'b1, lat);
    checkOutput("flushstart_lat",    lat,    32'd2);
    checkOutput("flushstart_result", result, 32'h00FF0008);

    // Reset in the middle of a shift
    @(negedge clk);
    op = 3'd4; len = 3'd7; carry_in = 1'b1; b_sign_ext = 1'b0;
    word1 = 32'h0; word2 = 32'h06000000; preinit = 32'hFFFFFFFF; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("midrun_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_result", result, 32'd0);
    checkOutput("midrst_flags",  {27'd0, ready, busy, done, carry_out, eq}, 32'b10000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midrst_stay_idle", {29'd0, ready, busy, done}, 32'b100);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
